// File: rtl/streaming_fifo_param.sv
// streaming_fifo_param: first-word-fall-through stream FIFO with occupancy, peak and threshold flags
module streaming_fifo_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16384,
    parameter int AFULL_LEVEL = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in0_V_V_TDATA,
    input  logic             in0_V_V_TVALID,
    output logic             in0_V_V_TREADY,
    output logic [WIDTH-1:0] out_V_V_TDATA,
    output logic             out_V_V_TVALID,
    input  logic             out_V_V_TREADY,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    max_count,
    input  logic             max_clr,
    output logic             almost_full,
    output logic             almost_empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push, pop;
    assign in0_V_V_TREADY = (count < CW'(DEPTH)) && !ap_rst;
    assign out_V_V_TVALID = count != '0;
    assign out_V_V_TDATA  = mem[rd_ptr];
    assign push = in0_V_V_TVALID && in0_V_V_TREADY;
    assign pop  = out_V_V_TVALID && out_V_V_TREADY;
    assign almost_full  = int'(count) >= AFULL_LEVEL;
    assign almost_empty = int'(count) <= AEMPTY_LEVEL;
    always_comb begin
        count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
    end
    always_ff @(posedge ap_clk) begin
        if (push && !flush) mem[wr_ptr] <= in0_V_V_TDATA;
    end
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            count     <= '0;
            max_count <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            count     <= count_nxt;
            max_count <= (max_clr || count_nxt > max_count) ? count_nxt : max_count;
            rd_ptr    <= flush ? '0 : !pop ? rd_ptr : (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            wr_ptr    <= flush ? '0 : !push ? wr_ptr : (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_streaming_fifo_param.sv
// tb_streaming_fifo_param: directed scoreboard bench for a 5-deep, 8-bit FIFO
module tb_streaming_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] idata = '0;
    logic       ivalid = 1'b0;
    logic       iready;
    logic [7:0] odata;
    logic       ovalid;
    logic       ordy = 1'b0;
    logic [2:0] count, max_count;
    logic       max_clr = 1'b0;
    logic       afull, aempty;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];

    streaming_fifo_param #(.WIDTH(8), .DEPTH(5), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) dut (
        .ap_clk(clk), .ap_rst(rst), .flush(flush),
        .in0_V_V_TDATA(idata), .in0_V_V_TVALID(ivalid), .in0_V_V_TREADY(iready),
        .out_V_V_TDATA(odata), .out_V_V_TVALID(ovalid), .out_V_V_TREADY(ordy),
        .count(count), .max_count(max_count), .max_clr(max_clr),
        .almost_full(afull), .almost_empty(aempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard update at the negedge, where the inputs already hold what the next edge samples.
    task automatic cyc();
        @(negedge clk);
        if (rst || flush) q.delete();
        else begin
            if (ovalid && ordy) begin
                if (q.size() == 0) chk("sb_underflow", {24'd0, odata}, 32'hdead);
                else chk("sb_data", {24'd0, odata}, {24'd0, q.pop_front()});
            end
            if (ivalid && iready) q.push_back(idata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ivalid = 1'b0;
        ordy = 1'b1;
        for (int k = 0; k < 50 && count != 0; k++) cyc();
        chk("drain_count", {29'd0, count}, 0);
        chk("drain_sb_empty", q.size(), 0);
    endtask

    initial begin
        int idx;
        bit p;
        cyc();
        cyc();
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_max", {29'd0, max_count}, 0);
        chk("rst_ovalid", {31'd0, ovalid}, 0);
        chk("rst_iready", {31'd0, iready}, 0);
        chk("rst_aempty", {31'd0, aempty}, 1);
        chk("rst_afull", {31'd0, afull}, 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_iready", {31'd0, iready}, 1);

        for (int i = 0; i < 5; i++) begin
            ivalid = 1'b1;
            idata = 8'h10 + 8'(i);
            cyc();
            chk("fill_count", {29'd0, count}, i + 1);
            chk("fill_afull", {31'd0, afull}, {31'd0, i + 1 >= 4});
            chk("fill_aempty", {31'd0, aempty}, {31'd0, i + 1 <= 1});
            chk("fill_iready", {31'd0, iready}, {31'd0, i + 1 < 5});
            chk("fill_ovalid", {31'd0, ovalid}, 1);
            chk("fill_hold_data", {24'd0, odata}, 32'h10);
        end
        idata = 8'h15;
        cyc();
        chk("full_holdoff_count", {29'd0, count}, 5);
        ordy = 1'b1;
        cyc();
        chk("full_pushpop_count", {29'd0, count}, 4);
        chk("full_pushpop_iready", {31'd0, iready}, 1);
        cyc();
        chk("steady_count", {29'd0, count}, 4);
        drain();
        chk("fill_max", {29'd0, max_count}, 5);
        chk("empty_aempty", {31'd0, aempty}, 1);

        idx = 0;
        for (int k = 0; k < 400 && idx < 20; k++) begin
            ivalid = 1'b1;
            idata = 8'(idx);
            ordy = 1'($urandom_range(0, 1));
            p = ivalid && iready;
            cyc();
            if (p) idx++;
        end
        chk("wrap_all_pushed", idx, 20);
        drain();
        chk("wrap_max_le5", {31'd0, max_count <= 3'd5}, 1);

        ordy = 1'b0;
        ivalid = 1'b1;
        idata = 8'h20;
        cyc();
        idata = 8'h21;
        cyc();
        chk("pre_clr_count", {29'd0, count}, 2);
        chk("pre_clr_max", {29'd0, max_count}, 5);
        max_clr = 1'b1;
        idata = 8'h22;
        cyc();
        max_clr = 1'b0;
        chk("clr_max", {29'd0, max_count}, 3);
        chk("clr_count", {29'd0, count}, 3);

        flush = 1'b1;
        idata = 8'hAA;
        cyc();
        flush = 1'b0;
        ivalid = 1'b0;
        chk("flush_count", {29'd0, count}, 0);
        chk("flush_ovalid", {31'd0, ovalid}, 0);
        chk("flush_max", {29'd0, max_count}, 3);
        ordy = 1'b1;
        cyc();
        cyc();
        chk("flush_no_aa", {31'd0, ovalid}, 0);
        ivalid = 1'b1;
        idata = 8'h30;
        cyc();
        drain();

        ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b1;
            idata = 8'h40 + 8'(i);
            cyc();
        end
        chk("pre_rst_count", {29'd0, count}, 4);
        ivalid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("midrst_count", {29'd0, count}, 0);
        chk("midrst_ovalid", {31'd0, ovalid}, 0);
        chk("midrst_iready", {31'd0, iready}, 0);
        chk("midrst_max", {29'd0, max_count}, 0);
        rst = 1'b0;
        cyc();
        chk("rel_iready", {31'd0, iready}, 1);
        chk("rel_ovalid", {31'd0, ovalid}, 0);
        ivalid = 1'b1;
        idata = 8'h50;
        cyc();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/streaming_fifo_param.md
STREAMING_FIFO_PARAM -- requirements
Module: streaming_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: stream data width in bits, legal range 1..1024.
REQ-002 SHALL have parameter DEPTH, default 16384: storage capacity in words, legal range 2..65536, any integer (not restricted to powers of two).
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2: almost_full threshold.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 2: almost_empty threshold.
REQ-005 SHALL derive CW = clog2(DEPTH+1), the width of all occupancy ports.
REQ-006 SHALL have these ports:
- ap_clk  in  1  sole clock; all logic on its rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous discard of all stored words.
- in0_V_V_TDATA  in  WIDTH  input stream data.
- in0_V_V_TVALID  in  1  input valid.
- in0_V_V_TREADY  out  1  input ready.
- out_V_V_TDATA  out  WIDTH  output stream data.
- out_V_V_TVALID  out  1  output valid.
- out_V_V_TREADY  in  1  output ready.
- count  out  CW  current occupancy.
- max_count  out  CW  peak occupancy since the last reset or clear.
- max_clr  in  1  clears the peak tracker.
- almost_full  out  1  high when count >= AFULL_LEVEL.
- almost_empty  out  1  high when count <= AEMPTY_LEVEL.

Function
REQ-007 SHALL define push = in TVALID & in TREADY and pop = out TVALID & out TREADY, each sampled at the clock edge.
REQ-008 SHALL drive in0_V_V_TREADY = (count < DEPTH) & !ap_rst from registered state only, with no combinational path from out_V_V_TREADY.
REQ-009 SHALL present the oldest stored word in first-word-fall-through fashion: out_V_V_TVALID = (count != 0).
REQ-010 SHALL give a word pushed at edge N TVALID on the output from edge N+1 when the FIFO was empty; latency is 1 cycle with no bubbles at full throughput.
REQ-011 SHALL update count as follows, saturation-free: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-012 SHALL sustain one push and one pop per cycle indefinitely at any occupancy from 1 to DEPTH-1.
REQ-013 SHALL hold in TREADY low when full (count == DEPTH); a pop in a full cycle raises TREADY in the next cycle, with no same-cycle bypass.
REQ-014 SHALL not pop while empty; a push into an empty FIFO does not bypass to the output in the same cycle.
REQ-015 SHALL keep out_V_V_TDATA stable while TVALID is high and TREADY is low.
REQ-016 SHALL wrap the read and write pointers from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-017 SHALL preserve word order and never duplicate or drop an accepted word, except on flush or reset.
REQ-018 SHALL act on flush as follows: next-cycle count = 0, out TVALID = 0, pointers reset, and any push or pop in the flush cycle ignored; max_count is retained.
REQ-019 SHALL update max_count each cycle to max(max_count, next count).
REQ-020 SHALL load max_count with the next count on max_clr, taking priority over the max update.
REQ-021 SHALL compute almost_full and almost_empty combinationally from the registered count.
REQ-022 SHALL apply event priority: ap_rst > flush > push/pop; max_clr is independent of flush.

Reset
REQ-023 SHALL, while ap_rst is high, drive count = 0, max_count = 0, out_V_V_TVALID = 0, in0_V_V_TREADY = 0, almost_empty = 1, almost_full = 0 (for AFULL_LEVEL > 0).
REQ-024 SHALL drive in0_V_V_TREADY = 1 in the first cycle after ap_rst deasserts; out_V_V_TDATA is don't-care while TVALID = 0.
REQ-025 SHALL discard stored contents on a reset asserted mid-transfer; no word accepted before reset appears afterwards.

Verification (WIDTH=8, DEPTH=5, AFULL_LEVEL=4, AEMPTY_LEVEL=1)
REQ-026 SHALL cover fill to full: push 0x10..0x14 with out TREADY=0 -> count 1..5, TREADY low after 5th push, almost_full high at count 4, 6th word held off.
REQ-027 SHALL cover simultaneous push/pop at full: both TREADYs=1 while full -> pop only in that cycle, count 4, TREADY high next cycle, output order 0x10,0x11,...
REQ-028 SHALL cover wrap-around: stream 20 words 0x00..0x13 at full rate with random out TREADY -> output identical order, max_count <= 5, count returns to 0.
REQ-029 SHALL cover flush: flush with count=3 plus a concurrent push of 0xAA -> count 0 and TVALID 0 next cycle, 0xAA never emitted, max_count unchanged.
REQ-030 SHALL cover max_clr: max_count=5, count=2, assert max_clr with a concurrent push -> max_count=3.
REQ-031 SHALL cover reset mid-operation: ap_rst at count=4 -> count 0, TVALID 0, TREADY 0 during reset, TREADY 1 one cycle after release.
